// File: rtl/mm_seq_mac_controller_pkg.sv
// Shared definitions for the sequential 3x3 by 3x1 MAC controller:
// default widths, loop dimensions, FSM state encodings and index helper.
package mm_seq_mac_controller_pkg;

    localparam int FACTOR_WIDTH_DEFAULT  = 8;
    localparam int PRODUCT_WIDTH_DEFAULT = 2 * FACTOR_WIDTH_DEFAULT;
    localparam int RESULT_WIDTH_DEFAULT  = PRODUCT_WIDTH_DEFAULT + 2;

    localparam int MM_DIM     = 3;
    localparam int MM_NUM_MAC = MM_DIM * MM_DIM;

    typedef enum logic [1:0] {
        MM_ST_IDLE = 2'd0,
        MM_ST_MAC  = 2'd1,
        MM_ST_DONE = 2'd2
    } mm_state_t;

    // Row-major flat index of A[i][j].
    function automatic logic [3:0] mm_flat_idx(input logic [1:0] i,
                                               input logic [1:0] j);
        return 4'(i) * 4'(MM_DIM) + 4'(j);
    endfunction

endpackage

// File: rtl/mm_seq_mac_controller_if.sv
// Operand/result valid-ready bundle of the sequential MAC controller.
// Ports: in_valid/in_ready/a_flat/b_flat upstream; out_valid/out_ready/c_flat downstream.
interface mm_seq_mac_controller_if #(
    parameter int NBITS        = 8,
    parameter int RESULT_WIDTH = 18
);
    logic                      in_valid;
    logic                      in_ready;
    logic [9*NBITS-1:0]        a_flat;
    logic [3*NBITS-1:0]        b_flat;
    logic                      out_valid;
    logic                      out_ready;
    logic [3*RESULT_WIDTH-1:0] c_flat;

    modport master (
        output in_valid, a_flat, b_flat, out_ready,
        input  in_ready, out_valid, c_flat
    );

    modport slave (
        input  in_valid, a_flat, b_flat, out_ready,
        output in_ready, out_valid, c_flat
    );
endinterface

// File: rtl/mm_seq_mac_controller_mac_unit.sv
// mm_mac_unit: combinational signed multiply, sign-extend and accumulate.
// Ports: i_a, i_b factors; i_acc running sum; i_clr starts a new row;
// o_sum result; o_ovf saturation flag (only with MM_SATURATE_EN).
module mm_mac_unit #(
    parameter int NBITS        = 8,
    parameter int RESULT_WIDTH = 18
) (
    input  logic signed [NBITS-1:0]        i_a,
    input  logic signed [NBITS-1:0]        i_b,
    input  logic signed [RESULT_WIDTH-1:0] i_acc,
    input  logic                           i_clr,
`ifdef MM_SATURATE_EN
    output logic                           o_ovf,
`endif
    output logic signed [RESULT_WIDTH-1:0] o_sum
);
    localparam int PW = 2 * NBITS;

    logic signed [PW-1:0]         w_prod;
    logic signed [RESULT_WIDTH:0] w_pext;
    logic signed [RESULT_WIDTH:0] w_base;
    logic signed [RESULT_WIDTH:0] w_wide;

    assign w_prod = i_a * i_b;
    assign w_pext = (RESULT_WIDTH+1)'(w_prod);
    assign w_base = i_clr ? '0 : (RESULT_WIDTH+1)'(i_acc);
    // One guard bit: the top two bits differ only on overflow.
    assign w_wide = w_base + w_pext;

`ifdef MM_SATURATE_EN
    logic w_ovf;
    assign w_ovf = w_wide[RESULT_WIDTH] ^ w_wide[RESULT_WIDTH-1];
    assign o_ovf = w_ovf;
    always_comb begin
        o_sum = w_wide[RESULT_WIDTH-1:0];
        if (w_ovf) begin
            o_sum = w_wide[RESULT_WIDTH]
                  ? {1'b1, {(RESULT_WIDTH-1){1'b0}}}
                  : {1'b0, {(RESULT_WIDTH-1){1'b1}}};
        end
    end
`else
    assign o_sum = w_wide[RESULT_WIDTH-1:0];
`endif
endmodule

// File: rtl/mm_seq_mac_controller.sv
// Sequential C = A x B (3x3 by 3x1, signed) on one MAC unit, 9 steps per job.
// Ports: clk, rst_n, abort, busy, bus (slave: operands in, results out);
// ovf sticky overflow only when MM_SATURATE_EN is defined.
module mm_seq_mac_controller
    import mm_seq_mac_controller_pkg::*;
#(
    parameter int NBITS        = FACTOR_WIDTH_DEFAULT,
    parameter int RESULT_WIDTH = RESULT_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic abort,
    output logic busy,
`ifdef MM_SATURATE_EN
    output logic ovf,
`endif
    mm_seq_mac_controller_if.slave bus
);
    mm_state_t                     r_state;
    logic [8:0][NBITS-1:0]         r_a;
    logic [2:0][NBITS-1:0]         r_b;
    logic [2:0][RESULT_WIDTH-1:0]  r_c;
    logic signed [RESULT_WIDTH-1:0] r_acc;
    logic [1:0]                    r_i;
    logic [1:0]                    r_j;
    logic                          r_in_ready;
    logic                          r_out_valid;
    logic                          r_busy;

    logic [3:0]                     w_idx;
    logic signed [RESULT_WIDTH-1:0] w_sum;
    logic                           w_last_j;
    logic                           w_last_i;

    assign w_idx    = mm_flat_idx(r_i, r_j);
    assign w_last_j = (r_j == 2'(MM_DIM - 1));
    assign w_last_i = (r_i == 2'(MM_DIM - 1));

`ifdef MM_SATURATE_EN
    logic w_ovf;
    logic r_ovf;
    assign ovf = r_ovf;
`endif

    mm_mac_unit #(
        .NBITS        (NBITS),
        .RESULT_WIDTH (RESULT_WIDTH)
    ) u_mac (
        .i_a   (r_a[w_idx]),
        .i_b   (r_b[r_j]),
        .i_acc (r_acc),
        .i_clr (r_j == 2'd0),
`ifdef MM_SATURATE_EN
        .o_ovf (w_ovf),
`endif
        .o_sum (w_sum)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.c_flat    = r_c;
    assign busy          = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= MM_ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_acc       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MM_SATURATE_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                MM_ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a_flat;
                        r_b        <= bus.b_flat;
                        r_acc      <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= MM_ST_MAC;
`ifdef MM_SATURATE_EN
                        r_ovf      <= 1'b0;
`endif
                    end
                end
                MM_ST_MAC: begin
                    if (abort) begin
                        // Dropped job: rows already written stay in r_c.
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= MM_ST_IDLE;
                    end else begin
                        r_acc <= w_sum;
`ifdef MM_SATURATE_EN
                        r_ovf <= r_ovf | w_ovf;
`endif
                        if (w_last_j) begin
                            r_c[r_i] <= w_sum;
                            r_j      <= '0;
                            if (w_last_i) begin
                                r_i         <= '0;
                                r_busy      <= 1'b0;
                                r_out_valid <= 1'b1;
                                r_state     <= MM_ST_DONE;
                            end else begin
                                r_i <= r_i + 2'd1;
                            end
                        end else begin
                            r_j <= r_j + 2'd1;
                        end
                    end
                end
                MM_ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= MM_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= MM_ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mm_seq_mac_controller.sv
// Self-checking bench for mm_seq_mac_controller (18-bit and 16-bit results).
// Table-driven jobs plus backpressure, abort, async reset and overflow sequences.
module tb_mm_seq_mac_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic abort16 = 1'b0;
    logic busy0, busy16;
`ifdef MM_SATURATE_EN
    logic ovf0, ovf16;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mm_seq_mac_controller_if #(.NBITS(8), .RESULT_WIDTH(18)) if0 ();
    mm_seq_mac_controller_if #(.NBITS(8), .RESULT_WIDTH(16)) if16 ();

    mm_seq_mac_controller #(.NBITS(8), .RESULT_WIDTH(18)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (abort),
        .busy  (busy0),
`ifdef MM_SATURATE_EN
        .ovf   (ovf0),
`endif
        .bus   (if0.slave)
    );

    mm_seq_mac_controller #(.NBITS(8), .RESULT_WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (abort16),
        .busy  (busy16),
`ifdef MM_SATURATE_EN
        .ovf   (ovf16),
`endif
        .bus   (if16.slave)
    );

    typedef struct {
        int a[9];
        int b[3];
        int c[3];
    } vec_t;

    vec_t vt[4];
    vec_t v_b2b;
    vec_t v_789;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint c_of(input int i);
        logic [17:0] t;
        t = if0.c_flat[i*18 +: 18];
        return longint'($signed(t));
    endfunction

    function automatic longint c16_of(input int i);
        logic [15:0] t;
        t = if16.c_flat[i*16 +: 16];
        return longint'($signed(t));
    endfunction

    task automatic start(input vec_t v);
        for (int n = 0; n < 9; n++) if0.a_flat[n*8 +: 8] = 8'(v.a[n]);
        for (int n = 0; n < 3; n++) if0.b_flat[n*8 +: 8] = 8'(v.b[n]);
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        // Operands scrambled after accept must not affect the job.
        if0.a_flat = {9{8'h5a}};
        if0.b_flat = {3{8'ha5}};
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (if0.out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_c(input vec_t v, input string nm);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s C[%0d]", nm, i), c_of(i), longint'(v.c[i]));
    endtask

    task automatic release_result(input string nm);
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        if0.out_ready = 1'b0;
        chk({nm, " out_valid cleared"}, longint'(if0.out_valid), 0);
        chk({nm, " in_ready back"}, longint'(if0.in_ready), 1);
    endtask

    task automatic full_job(input vec_t v, input string nm);
        int lat;
        start(v);
        chk({nm, " in_ready low"}, longint'(if0.in_ready), 0);
        chk({nm, " busy high"}, longint'(busy0), 1);
        wait_done(lat);
        chk({nm, " latency"}, longint'(lat), 9);
        check_c(v, nm);
`ifdef MM_SATURATE_EN
        chk({nm, " ovf"}, longint'(ovf0), 0);
`endif
        release_result(nm);
    endtask

    initial begin
        logic [53:0] held;
        int lat;

        vt[0].a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        vt[0].b = '{3, -4, 5};
        vt[0].c = '{3, -4, 5};
        vt[1].a = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
        vt[1].b = '{-128, -128, -128};
        vt[1].c = '{49152, 49152, 49152};
        vt[2].a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        vt[2].b = '{1, -1, 2};
        vt[2].c = '{5, 11, 17};
        vt[3].a = '{127, -128, 0, -1, -1, -1, 10, 20, 30};
        vt[3].b = '{127, 127, -128};
        vt[3].c = '{-127, -126, -30};
        v_b2b.a = '{1, 0, 0, 2, 0, 0, 3, 0, 0};
        v_b2b.b = '{2, 0, 0};
        v_b2b.c = '{2, 4, 6};
        v_789.a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        v_789.b = '{7, 8, 9};
        v_789.c = '{7, 8, 9};

        if0.in_valid = 1'b0;
        if0.out_ready = 1'b0;
        if0.a_flat = '0;
        if0.b_flat = '0;
        if16.in_valid = 1'b0;
        if16.out_ready = 1'b0;
        if16.a_flat = '0;
        if16.b_flat = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", longint'(if0.in_ready), 1);
        chk("reset out_valid", longint'(if0.out_valid), 0);
        chk("reset busy", longint'(busy0), 0);
        chk("reset c_flat", longint'(if0.c_flat), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven jobs
        for (int n = 0; n < 4; n++) full_job(vt[n], $sformatf("vec%0d", n));

        // Backpressure then back-to-back job
        start(vt[2]);
        wait_done(lat);
        chk("bp latency", longint'(lat), 9);
        held = if0.c_flat;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            chk("bp c stable", longint'(if0.c_flat), longint'(held));
            chk("bp in_ready low", longint'(if0.in_ready), 0);
            chk("bp out_valid", longint'(if0.out_valid), 1);
        end
        release_result("bp");
        full_job(v_b2b, "b2b");

        // Abort at k=4
        start(vt[2]);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort in_ready", longint'(if0.in_ready), 1);
        chk("abort busy", longint'(busy0), 0);
        chk("abort C0 written", c_of(0), 5);
        chk("abort C1 kept", c_of(1), 4);
        lat = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (if0.out_valid) lat++;
        end
        chk("abort no out_valid", longint'(lat), 0);
        full_job(v_789, "post-abort");

        // Async reset mid-MAC
        start(vt[3]);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset in_ready", longint'(if0.in_ready), 1);
        chk("areset busy", longint'(busy0), 0);
        chk("areset out_valid", longint'(if0.out_valid), 0);
        chk("areset c_flat", longint'(if0.c_flat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        full_job(vt[0], "post-reset");

        // 16-bit result overflow
        if16.a_flat = {9{8'h80}};
        if16.b_flat = {3{8'h80}};
        if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (if16.out_valid) begin
                lat = n;
                break;
            end
        end
        chk("ovf16 latency", longint'(lat), 9);
        for (int i = 0; i < 3; i++) begin
`ifdef MM_SATURATE_EN
            chk($sformatf("ovf16 C[%0d]", i), c16_of(i), 32767);
`else
            chk($sformatf("ovf16 C[%0d]", i), c16_of(i), -16384);
`endif
        end
`ifdef MM_SATURATE_EN
        chk("ovf16 flag", longint'(ovf16), 1);
`endif
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        if16.out_ready = 1'b0;
        chk("ovf16 released", longint'(if16.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
